pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse (>=2).
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized-lock cycles required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK per attempt (>=2).
REQ-004 SHALL have parameter MAX_RETRY, default 3: timed-out attempts tolerated before FAULT (1..15).
REQ-005 refclk  in  1: single clock, the 50 MHz PLL reference; all logic on its rising edge.
REQ-006 rst_n  in  1: asynchronous, active-low reset.
REQ-007 pll_locked  in  1: PLL locked output, asynchronous to refclk.
REQ-008 relock_req  in  1: single-cycle synchronous request to restart the PLL sequence.
REQ-009 pll_rst  out  1: drives the PLL reset input, active-high.
REQ-010 sys_rst_n  out  1: active-low reset for logic clocked by the PLL output.
REQ-011 ready  out  1: high only in RUN.
REQ-012 fault  out  1: high only in FAULT.
REQ-013 retry_cnt  out  4: timed-out attempts since the last successful lock or relock_req.
REQ-014 lock_lost  out  1: one-cycle pulse on each loss of lock while in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); sequencing uses only locked_s, giving 2 cycles of input latency.
REQ-016 States SHALL be RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT; all outputs registered.
REQ-017 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the counter cleared.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE with counter cleared; after LOCK_TIMEOUT cycles without lock -> retry_cnt+1, then FAULT if the new value equals MAX_RETRY, else RESET_PLL.
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK with the counter cleared; after LOCK_STABLE consecutive cycles with locked_s=1 -> RUN with retry_cnt cleared.
REQ-020 RUN: sys_rst_n=1 and ready=1 starting the cycle after entry; locked_s=0 -> lock_lost pulse, sys_rst_n=0 and ready=0 on the next edge, then next state per REQ-028.
REQ-021 FAULT: pll_rst=1, sys_rst_n=0, fault=1; the only exit is relock_req.
REQ-022 relock_req in any state SHALL force RESET_PLL with the counter and retry_cnt cleared, and has priority over lock loss and timeout in the same cycle; relock_req while already in RESET_PLL restarts the RST_CYCLES count.
REQ-023 sys_rst_n SHALL be 0 in every state except RUN; its deassertion is synchronous to refclk.
REQ-024 The counter SHALL be 24 bits; a parameter value above 2^24 SHALL be an elaboration error. retry_cnt does not wrap (bounded by MAX_RETRY).

Reset
REQ-025 While rst_n=0 (asynchronous): state=RESET_PLL, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_lost=0, synchronizer flops=0.
REQ-026 On rst_n release the full RST_CYCLES pulse SHALL be counted from the first edge; reset asserted mid-sequence at any state returns all values to REQ-025.

Configuration
REQ-027 Macro PLL_RST_SEQ_AUTO_RELOCK_EN SHALL select behaviour on loss of lock in RUN.
REQ-028 Defined: RUN with lock loss -> RESET_PLL (automatic relock, retry_cnt unchanged); undefined: RUN with lock loss -> FAULT. lock_lost pulses in both cases.

Structure
REQ-029 Package fclk_pkg SHALL hold the state enum, the 24-bit counter width constant, and the default parameter values.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, async active-low reset to 0).

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=3)
REQ-031 Release rst_n with pll_locked tied high -> pll_rst high for 4 cycles, sys_rst_n=1 and ready=1 at cycle 4+2+8+a fixed registered offset, checked exactly.
REQ-032 pll_locked tied low -> three 32-cycle WAIT_LOCK windows with retry_cnt 1, 2, then fault=1 and pll_rst=1 with retry_cnt=3; relock_req -> RESET_PLL and retry_cnt=0.
REQ-033 Glitch pll_locked low for 1 cycle at STABLE count 5 -> returns to WAIT_LOCK; RUN needs a fresh 8 consecutive cycles.
REQ-034 In RUN drop pll_locked -> one-cycle lock_lost, sys_rst_n=0 within 3 cycles; macro defined -> pll_rst pulse and relock; macro undefined -> fault=1.
REQ-035 relock_req and the lock drop in the same cycle in RUN -> RESET_PLL in both builds, retry_cnt=0, fault stays 0.
REQ-036 Assert rst_n in WAIT_LOCK at retry_cnt=2 -> all outputs match REQ-025 immediately (asynchronous), and the sequence restarts cleanly.

Source files
------------

// File: rtl/fclk_pkg.sv
// Shared types and constants for the PLL reset sequencer: state encoding,
// counter width and default parameter values.
package fclk_pkg;

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned CNT_MAX = 32'd1 << CNT_W;

  localparam int unsigned RST_CYCLES_DEF   = 16;
  localparam int unsigned LOCK_STABLE_DEF  = 1024;
  localparam int unsigned LOCK_TIMEOUT_DEF = 65536;
  localparam int unsigned MAX_RETRY_DEF    = 3;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases sys_rst_n. Define PLL_RST_SEQ_AUTO_RELOCK_EN to relock on lock loss.
module pll_rst_seq
  import fclk_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = RST_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  if (RST_CYCLES < 2 || RST_CYCLES > CNT_MAX) begin : g_bad_rst
    $error("RST_CYCLES out of range");
  end
  if (LOCK_STABLE < 1 || LOCK_STABLE > CNT_MAX) begin : g_bad_stable
    $error("LOCK_STABLE out of range");
  end
  if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > CNT_MAX) begin : g_bad_timeout
    $error("LOCK_TIMEOUT out of range");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
    $error("MAX_RETRY out of range");
  end

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  logic             locked_s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       retry_nx;
  logic             pll_rst_nx, run_nx, fault_nx, lock_lost_nx;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry_cnt <= retry_nx;
      pll_rst   <= pll_rst_nx;
      sys_rst_n <= run_nx;
      ready     <= run_nx;
      fault     <= fault_nx;
      lock_lost <= lock_lost_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    retry_nx = retry_cnt;
    if (relock_req) begin
      state_nx = RESET_PLL;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = STABLE;
            cnt_nx   = '0;
          end else if (cnt == TMO_LAST) begin
            cnt_nx   = '0;
            retry_nx = retry_cnt + 4'd1;
            state_nx = (retry_nx == RETRY_LIMIT) ? FAULT : RESET_PLL;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STB_LAST) begin
            state_nx = RUN;
            cnt_nx   = '0;
            retry_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
`ifdef PLL_RST_SEQ_AUTO_RELOCK_EN
            state_nx = RESET_PLL;
            cnt_nx   = '0;
`else
            state_nx = FAULT;
`endif
          end
        end
        FAULT:   state_nx = FAULT;
        default: state_nx = RESET_PLL;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it;
  // run_nx needs RUN on both sides, delaying release by one cycle after entry
  // and dropping it on the same edge that leaves RUN.
  always_comb begin
    pll_rst_nx   = (state_nx == RESET_PLL) || (state_nx == FAULT);
    run_nx       = (state == RUN) && (state_nx == RUN);
    fault_nx     = (state_nx == FAULT);
    lock_lost_nx = (state == RUN) && !locked_s;
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed self-checking bench for pll_rst_seq with small parameters;
// expectations follow PLL_RST_SEQ_AUTO_RELOCK_EN when it is defined.
module tb_pll_rst_seq;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault, lock_lost;
  logic [3:0] retry_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pll_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (32),
    .MAX_RETRY    (3)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pll_rst"},   32'(pll_rst),   32'd1);
    check({tag, ".sys_rst_n"}, 32'(sys_rst_n), 32'd0);
    check({tag, ".ready"},     32'(ready),     32'd0);
    check({tag, ".fault"},     32'(fault),     32'd0);
    check({tag, ".retry"},     32'(retry_cnt), 32'd0);
    check({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
  endtask

  // Holds reset for two cycles, then releases at a falling edge so the
  // next rising edge is edge 1 of the sequence.
  task automatic do_reset(input logic locked);
    rst_n      = 1'b0;
    relock_req = 1'b0;
    pll_locked = locked;
    repeat (2) @(negedge refclk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // Lock high from the start: release at edge 14.
    do_reset(1'b1);
    step(1);  check("t1.pll_rst_e1", 32'(pll_rst), 32'd1);
    step(2);  check("t1.pll_rst_e3", 32'(pll_rst), 32'd1);
    step(1);  check("t1.pll_rst_e4", 32'(pll_rst), 32'd0);
    step(9);  check("t1.sys_rst_e13", 32'(sys_rst_n), 32'd0);
              check("t1.ready_e13",   32'(ready),     32'd0);
    step(1);  check("t1.sys_rst_e14", 32'(sys_rst_n), 32'd1);
              check("t1.ready_e14",   32'(ready),     32'd1);
              check("t1.retry_e14",   32'(retry_cnt), 32'd0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    step(2);  check("t2.lock_lost_e16", 32'(lock_lost), 32'd0);
              check("t2.sys_rst_e16",   32'(sys_rst_n), 32'd1);
    step(1);  check("t2.lock_lost_e17", 32'(lock_lost), 32'd1);
              check("t2.sys_rst_e17",   32'(sys_rst_n), 32'd0);
              check("t2.ready_e17",     32'(ready),     32'd0);
              check("t2.pll_rst_e17",   32'(pll_rst),   32'd1);
`ifdef PLL_RST_SEQ_AUTO_RELOCK_EN
              check("t2.fault_e17",     32'(fault),     32'd0);
`else
              check("t2.fault_e17",     32'(fault),     32'd1);
`endif
    step(1);  check("t2.lock_lost_e18", 32'(lock_lost), 32'd0);

    // relock_req coincident with lock loss in RUN.
    do_reset(1'b1);
    step(14); check("t3.sys_rst_e14", 32'(sys_rst_n), 32'd1);
    pll_locked = 1'b0;
    step(2);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
              check("t3.pll_rst", 32'(pll_rst),   32'd1);
              check("t3.fault",   32'(fault),     32'd0);
              check("t3.retry",   32'(retry_cnt), 32'd0);
              check("t3.sys_rst", 32'(sys_rst_n), 32'd0);
    step(1);  check("t3.fault_next", 32'(fault), 32'd0);

    // One-cycle lock glitch while STABLE count is 5.
    do_reset(1'b1);
    step(8);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(5);  check("t4.sys_rst_e14", 32'(sys_rst_n), 32'd0);
    step(6);  check("t4.sys_rst_e20", 32'(sys_rst_n), 32'd0);
    step(1);  check("t4.sys_rst_e21", 32'(sys_rst_n), 32'd1);
              check("t4.ready_e21",   32'(ready),     32'd1);

    // Lock never arrives: three timeouts, then FAULT; relock_req recovers.
    do_reset(1'b0);
    step(35); check("t5.pll_rst_e35", 32'(pll_rst),   32'd0);
              check("t5.retry_e35",   32'(retry_cnt), 32'd0);
    step(1);  check("t5.retry_e36",   32'(retry_cnt), 32'd1);
              check("t5.pll_rst_e36", 32'(pll_rst),   32'd1);
    step(36); check("t5.retry_e72",   32'(retry_cnt), 32'd2);
    step(35); check("t5.fault_e107",  32'(fault),     32'd0);
              check("t5.retry_e107",  32'(retry_cnt), 32'd2);
    step(1);  check("t5.fault_e108",  32'(fault),     32'd1);
              check("t5.pll_rst_e108",32'(pll_rst),   32'd1);
              check("t5.retry_e108",  32'(retry_cnt), 32'd3);
              check("t5.sys_rst_e108",32'(sys_rst_n), 32'd0);
    step(5);  check("t5.fault_held",  32'(fault),     32'd1);
              check("t5.retry_held",  32'(retry_cnt), 32'd3);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
              check("t5.relock_fault", 32'(fault),     32'd0);
              check("t5.relock_rst",   32'(pll_rst),   32'd1);
              check("t5.relock_retry", 32'(retry_cnt), 32'd0);
    step(3);  check("t5.relock_rst3",  32'(pll_rst),   32'd1);
    step(1);  check("t5.relock_rst4",  32'(pll_rst),   32'd0);

    // Asynchronous reset in WAIT_LOCK with retry_cnt at 2.
    do_reset(1'b0);
    step(80); check("t6.retry_e80",   32'(retry_cnt), 32'd2);
              check("t6.pll_rst_e80", 32'(pll_rst),   32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6.async");
    pll_locked = 1'b1;
    @(negedge refclk);
    rst_n = 1'b1;
    step(13); check("t6.sys_rst_e13", 32'(sys_rst_n), 32'd0);
    step(1);  check("t6.sys_rst_e14", 32'(sys_rst_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
